// File: rtl/ctrl_50mhz_pkg.sv
// Shared types and constants for the ctrl_50mhz packet write controller.
package ctrl_50mhz_pkg;

  localparam logic [7:0] HDR_A5        = 8'hA5;
  localparam logic [7:0] HDR_C3        = 8'hC3;
  localparam int         PAYLOAD_BYTES = 4;

  // Width of the exported state debug bus.
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HDR_WAIT = 3'd0,
    BYTE1    = 3'd1,
    BYTE2    = 3'd2,
    BYTE3    = 3'd3,
    BYTE4    = 3'd4
  } state_e;

  // True for either of the two recognised header bytes.
  function automatic logic is_header(input logic [7:0] b);
    return (b == HDR_A5) || (b == HDR_C3);
  endfunction

endpackage

// File: rtl/ctrl_50mhz.sv
// Packet write controller: finds a header byte, then writes the following
// payload bytes into a FIFO, one registered write per byte.
// Optional feature macro: CTRL_50MHZ_PKT_CNT_EN enables the completed-packet
// counter; without it pkt_count is tied to zero.
//
// Handshake: data_ena/data is a one-cycle valid with no ready; a byte is
// consumed on every edge where data_ena=1. full is the FIFO's inverted ready
// and is only looked at on those same edges. wr/wr_data are a one-cycle
// write strobe issued the cycle after the byte was sampled; a byte seen
// while full=1 in a payload state is dropped and the packet is abandoned.
module ctrl_50mhz
  import ctrl_50mhz_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data_ena,
  input  logic [7:0]         data,
  input  logic               full,
  output logic               wr,
  output logic [7:0]         wr_data,
  output logic               pkt_done,
  output logic               overflow,
  output logic [CNT_W-1:0]   pkt_count,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       pkt_done_q, pkt_done_d;
  logic       overflow_q, overflow_d;
  logic       payload_sample;

`ifdef CTRL_50MHZ_PKT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= HDR_WAIT;
      wr_q       <= 1'b0;
      wr_data_q  <= 8'h00;
      pkt_done_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef CTRL_50MHZ_PKT_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      wr_data_q  <= wr_data_d;
      pkt_done_q <= pkt_done_d;
      overflow_q <= overflow_d;
`ifdef CTRL_50MHZ_PKT_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next state: advance only on sampled bytes; full in a payload state aborts.
  always_comb begin
    state_d = state_q;
    if (data_ena) begin
      unique case (state_q)
        HDR_WAIT: if (is_header(data)) state_d = BYTE1;
        BYTE1:    state_d = full ? HDR_WAIT : BYTE2;
        BYTE2:    state_d = full ? HDR_WAIT : BYTE3;
        BYTE3:    state_d = full ? HDR_WAIT : BYTE4;
        BYTE4:    state_d = HDR_WAIT;
        default:  state_d = HDR_WAIT;
      endcase
    end
  end

  // Output next values: write accepted payload, flag dropped payload.
  always_comb begin
    payload_sample = data_ena && (state_q != HDR_WAIT);
    wr_d           = payload_sample && !full;
    wr_data_d      = wr_d ? data : wr_data_q;
    pkt_done_d     = wr_d && (state_q == BYTE4);
    overflow_d     = overflow_q || (payload_sample && full);
  end

`ifdef CTRL_50MHZ_PKT_CNT_EN
  // Packet counter bumps on the same edge that registers pkt_done; wraps freely.
  always_comb begin
    cnt_d = pkt_done_d ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign pkt_count = cnt_q;
`else
  assign pkt_count = {CNT_W{1'b0}};
`endif

  assign wr        = wr_q;
  assign wr_data   = wr_data_q;
  assign pkt_done  = pkt_done_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ctrl_50mhz.sv
// Self-checking bench for ctrl_50mhz: a byte-stream reference model, a
// per-cycle compare process, an expected-write queue and directed checks.
module tb_ctrl_50mhz;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             data_ena;
  logic [7:0]       data;
  logic             full;
  logic             wr;
  logic [7:0]       wr_data;
  logic             pkt_done;
  logic             overflow;
  logic [CNT_W-1:0] pkt_count;
  logic [2:0]       state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  ctrl_50mhz #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_ena  (data_ena),
    .data      (data),
    .full      (full),
    .wr        (wr),
    .wr_data   (wr_data),
    .pkt_done  (pkt_done),
    .overflow  (overflow),
    .pkt_count (pkt_count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // left = payload bytes still owed to the current packet (0 = hunting header).
  int         left = 0;
  logic       model_valid = 1'b0;
  logic       m_wr, m_done, m_ovf;
  logic [7:0] m_wdata;
  int         m_pkts;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (!reset_n) begin
      left = 0; m_wr = 0; m_done = 0; m_ovf = 0; m_wdata = 8'h00; m_pkts = 0;
      exp_q.delete();
      model_valid = 1'b1;
    end else begin
      m_wr = 0; m_done = 0;
      if (data_ena) begin
        if (left == 0) begin
          if (data == 8'hA5 || data == 8'hC3) left = 4;
        end else if (full) begin
          m_ovf = 1; left = 0;
        end else begin
          m_wr = 1; m_wdata = data; exp_q.push_back(data);
          left = left - 1;
          if (left == 0) begin m_done = 1; m_pkts = m_pkts + 1; end
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] exp_count();
`ifdef CTRL_50MHZ_PKT_CNT_EN
    return CNT_W'(m_pkts % (1 << CNT_W));
`else
    return '0;
`endif
  endfunction

  // ---------------- monitor / compare ----------------
  logic [7:0] wr_log[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (model_valid) begin
      check("wr", {31'd0, wr}, {31'd0, m_wr});
      check("wr_data", {24'd0, wr_data}, {24'd0, m_wdata});
      check("pkt_done", {31'd0, pkt_done}, {31'd0, m_done});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("pkt_count", {28'd0, pkt_count}, {28'd0, exp_count()});
      if (wr === 1'b1) begin
        wr_log.push_back(wr_data);
        if (exp_q.size() == 0) check("exp_q_underflow", 32'd1, 32'd0);
        else check("exp_q_byte", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
      end
      if (pkt_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] b, input logic f, input int gap);
    data_ena = 1'b1; data = b; full = f;
    @(posedge clk); #1;
    data_ena = 1'b0;
    // full toggles freely while idle; it must not affect anything.
    repeat (gap) begin
      full = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      @(posedge clk); #1;
    end
    full = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pack_log();
    logic [31:0] v = 32'd0;
    foreach (wr_log[i]) v = {v[23:0], wr_log[i]};
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    reset_n = 1'b0; data_ena = 1'b0; data = 8'h00; full = 1'b0;
    idle(3);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_count", {28'd0, pkt_count}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    reset_n = 1'b1;

    // Basic packet.
    wr_log.delete(); d0 = done_cnt;
    send(8'hA5, 0, 0); send(8'h11, 0, 0); send(8'h22, 0, 0);
    send(8'h33, 0, 0); send(8'h44, 0, 0);
    idle(2);
    check("basic_log", pack_log(), 32'h11223344);
    check("basic_len", wr_log.size(), 32'd4);
    check("basic_done", done_cnt - d0, 32'd1);
`ifdef CTRL_50MHZ_PKT_CNT_EN
    check("basic_count", {28'd0, pkt_count}, 32'd1);
`else
    check("basic_count", {28'd0, pkt_count}, 32'd0);
`endif

    // Junk before header; header values as payload.
    wr_log.delete(); d0 = done_cnt;
    send(8'h00, 0, 0); send(8'h7F, 0, 0); send(8'hC3, 0, 0);
    send(8'hA5, 0, 0); send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0);
    idle(2);
    check("junk_log", pack_log(), 32'hA5010203);
    check("junk_done", done_cnt - d0, 32'd1);

    // Overflow abort, then a clean packet; overflow stays set.
    wr_log.delete();
    send(8'hC3, 0, 0); send(8'h55, 0, 0); send(8'hAA, 1, 0);
    idle(1);
    check("ovf_log", pack_log(), 32'h00000055);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_state", {29'd0, state_dbg}, 32'd0);
    wr_log.delete();
    send(8'hA5, 0, 0); send(8'h01, 0, 0); send(8'h02, 0, 0);
    send(8'h03, 0, 0); send(8'h04, 0, 0);
    idle(2);
    check("post_ovf_log", pack_log(), 32'h01020304);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-packet.
    send(8'hA5, 0, 0); send(8'h01, 0, 0); send(8'h02, 0, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_wr", {31'd0, wr}, 32'd0);
    check("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("mid_rst_done", {31'd0, pkt_done}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_count", {28'd0, pkt_count}, 32'd0);
    reset_n = 1'b1;
    wr_log.delete();
    send(8'h03, 0, 0); send(8'h04, 0, 0); send(8'h05, 0, 0);
    idle(2);
    check("mid_rst_log_len", wr_log.size(), 32'd0);

    // Random gaps give the same write sequence.
    wr_log.delete();
    send(8'hA5, 0, $urandom_range(0, 5)); send(8'h11, 0, $urandom_range(0, 5));
    send(8'h22, 0, $urandom_range(0, 5)); send(8'h33, 0, $urandom_range(0, 5));
    send(8'h44, 0, $urandom_range(0, 5));
    idle(2);
    check("gap_log", pack_log(), 32'h11223344);
    check("gap_len", wr_log.size(), 32'd4);

    // Randomised stream against the model.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 3))
        0: b = 8'hA5;
        1: b = 8'hC3;
        default: b = 8'($urandom);
      endcase
      send(b, ($urandom_range(0, 9) == 0), $urandom_range(0, 5));
    end
    idle(2);

    // Counter wrap: 2^CNT_W packets after reset.
    do_reset();
    d0 = done_cnt;
    for (int p = 0; p < (1 << CNT_W); p++) begin
      send(8'hC3, 0, 0);
      for (int k = 0; k < 4; k++) send(8'($urandom), 0, $urandom_range(0, 1));
    end
    idle(2);
    check("wrap_done", done_cnt - d0, 32'(1 << CNT_W));
    check("wrap_count", {28'd0, pkt_count}, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ctrl_50mhz.md
CTRL_50MHZ -- requirements
Module: ctrl_50mhz

Interface
REQ-001 Parameter CNT_W, default 16: width of the packet counter.
REQ-002 clk  input  1  single clock, 50 MHz write domain; all logic on posedge clk.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 data_ena  input  1  incoming byte valid, one cycle per byte.
REQ-005 data  input  8  incoming byte, sampled when data_ena=1.
REQ-006 full  input  1  FIFO full flag from the FIFO write port.
REQ-007 wr  output  1  FIFO write strobe, one cycle per accepted payload byte.
REQ-008 wr_data  output  8  byte presented to FIFO, valid while wr=1.
REQ-009 pkt_done  output  1  one-cycle pulse when the 4th payload byte of a packet is written.
REQ-010 overflow  output  1  sticky flag: a payload byte was dropped because full=1.
REQ-011 pkt_count  output  CNT_W  count of completed packets.

Function
REQ-012 Packet format SHALL be: one header byte (8'hA5 or 8'hC3) followed by exactly 4 payload bytes.
REQ-013 FSM states SHALL be HDR_WAIT, BYTE1, BYTE2, BYTE3, BYTE4; sampling happens only on cycles with data_ena=1, otherwise state holds.
REQ-014 In HDR_WAIT, data=A5 or C3 SHALL move to BYTE1; any other byte SHALL be discarded with no write.
REQ-015 In BYTEn with data_ena=1 and full=0, the byte SHALL be written and the FSM SHALL advance (BYTE4 returns to HDR_WAIT).
REQ-016 Header values inside payload states SHALL be treated as ordinary payload.
REQ-017 wr and wr_data SHALL be registered: asserted the cycle after the sampling edge (latency 1), wr high for exactly one cycle.
REQ-018 pkt_done SHALL pulse in the same cycle as wr for the BYTE4 byte; pkt_count SHALL increment on that same edge.
REQ-019 pkt_count SHALL wrap from all-ones to 0 without flagging.
REQ-020 In BYTEn with data_ena=1 and full=1: no write, overflow SHALL set, FSM SHALL abort to HDR_WAIT; remaining bytes of that packet are treated as header candidates.
REQ-021 full is checked on the sampling edge only; full rising the cycle after a sampled byte SHALL NOT cancel that byte's pending wr.
REQ-022 wr SHALL never assert while FSM is in HDR_WAIT and no payload byte was sampled.
REQ-023 wr_data SHALL hold its last value when wr=0.

Reset
REQ-024 reset_n=0 at a clk edge SHALL force state=HDR_WAIT, wr=0, wr_data=0, pkt_done=0, overflow=0, pkt_count=0.
REQ-025 Reset mid-packet SHALL discard the partial packet; bytes already written stay in the FIFO.
REQ-026 overflow SHALL clear only on reset.

Configuration
REQ-027 Macro CTRL_50MHZ_PKT_CNT_EN: defined -> pkt_count counter implemented per REQ-018/019; undefined -> no counter register, pkt_count tied to 0; all other behaviour identical.

Structure
REQ-028 Package ctrl_50mhz_pkg SHALL hold the FSM state enum and constants HDR_A5=8'hA5, HDR_C3=8'hC3, PAYLOAD_BYTES=4.
REQ-029 No sub-module: the FSM, output registers and counter live in ctrl_50mhz.

Verification
REQ-030 Bytes A5,11,22,33,44 with full=0 -> wr pulses with wr_data 11,22,33,44, each one cycle after its sample; pkt_done with 44; pkt_count=1.
REQ-031 Bytes 00,7F,C3,A5,01,02,03 -> 00,7F dropped; wr for A5,01,02,03; pkt_done on 03.
REQ-032 Header C3, payload 55, full=1 on the 2nd payload byte AA -> wr only for 55; overflow=1; FSM in HDR_WAIT; next A5,1,2,3,4 completes normally, overflow remains 1.
REQ-033 Reset asserted after header+2 payload bytes -> all outputs 0 next cycle; following 3 bytes not written until a new header.
REQ-034 data_ena gaps of 0-5 idle cycles between bytes -> identical write sequence; no extra wr pulses.
REQ-035 With macro defined, preload or drive 2^CNT_W packets -> pkt_count wraps to 0; without macro, pkt_count stays 0 throughout.
